// File: rtl/register_file_mp.sv
// register_file_mp: two-write / two-read register file with a per-register
// busy scoreboard (reserve on RSV, cleared by writes).
//
// Ports
//   Clk, Reset          : rising-edge clock, asynchronous active-high reset
//   WEN0/1, RW0/1, busW0/1 : write ports (port 1 wins on equal addresses)
//   RX, RY -> busX, busY   : combinational read ports
//   RSV, RR                : scoreboard reserve strobe and target register
//   busyX, busyY           : combinational busy flags of RX / RY
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the post-edge busy value) to the read ports.

module register_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WEN0,
    input  logic              WEN1,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] busW0,
    input  logic [DATA_W-1:0] busW1,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RR,
    output logic              busyX,
    output logic              busyY
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr0_en;
    logic wr1_en;
    logic rsv_en;

    logic [DATA_W-1:0] rd_x;
    logic [DATA_W-1:0] rd_y;
    logic              by_x;
    logic              by_y;

    // Address 0 is inert (no write, no reserve, reads zero) when hardwired.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr0_en = WEN0 && addr_ok(RW0);
    assign wr1_en = WEN1 && addr_ok(RW1);
    assign rsv_en = RSV  && addr_ok(RR);

    // Next state: port 0, then port 1 (port 1 wins), then reserve (reserve wins).
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr0_en) begin
            mem_d[RW0]  = busW0;
            busy_d[RW0] = 1'b0;
        end
        if (wr1_en) begin
            mem_d[RW1]  = busW1;
            busy_d[RW1] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[RR] = 1'b1;
        end
    end

    // Storage and scoreboard; reset clears everything immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Read port X.
    always_comb begin
        rd_x = mem_q[RX];
        by_x = busy_q[RX];
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && (RW1 == RX)) begin
            rd_x = busW1;
            by_x = rsv_en && (RR == RX);
        end else if (wr0_en && (RW0 == RX)) begin
            rd_x = busW0;
            by_x = rsv_en && (RR == RX);
        end
`endif
        if (Reset || !addr_ok(RX)) begin
            busX  = '0;
            busyX = 1'b0;
        end else begin
            busX  = rd_x;
            busyX = by_x;
        end
    end

    // Read port Y.
    always_comb begin
        rd_y = mem_q[RY];
        by_y = busy_q[RY];
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && (RW1 == RY)) begin
            rd_y = busW1;
            by_y = rsv_en && (RR == RY);
        end else if (wr0_en && (RW0 == RY)) begin
            rd_y = busW0;
            by_y = rsv_en && (RR == RY);
        end
`endif
        if (Reset || !addr_ok(RY)) begin
            busY  = '0;
            busyY = 1'b0;
        end else begin
            busY  = rd_y;
            busyY = by_y;
        end
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The module SHALL have the parameter DATA_W, default 32, meaning register and data bus width in bits.
REQ-002 The module SHALL have the parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W registers.
REQ-003 The module SHALL have the parameter ZERO_REG, default 1, meaning that 1 hardwires register 0 to zero and 0 makes register 0 ordinary.
REQ-004 The module SHALL have the port Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have the port Reset  input  1  asynchronous, active-high reset.
REQ-006 The module SHALL have the ports WEN0 / WEN1  input  1 each  write enables, ports 0 and 1.
REQ-007 The module SHALL have the ports RW0 / RW1  input  ADDR_W each  write addresses.
REQ-008 The module SHALL have the ports busW0 / busW1  input  DATA_W each  write data.
REQ-009 The module SHALL have the ports RX / RY  input  ADDR_W each  read addresses.
REQ-010 The module SHALL have the ports busX / busY  output  DATA_W each  read data.
REQ-011 The module SHALL have the port RSV  input  1  scoreboard reserve strobe.
REQ-012 The module SHALL have the port RR  input  ADDR_W  register to reserve.
REQ-013 The module SHALL have the ports busyX / busyY  output  1 each  pending-write flag of RX / RY.

Function
REQ-014 Reads SHALL be combinational: busX = reg[RX] and busY = reg[RY], with zero cycles of latency.
REQ-015 A write SHALL commit on a rising Clk edge for each port whose WEN is 1, with reg[RWn] <= busWn.
REQ-016 When both ports are enabled and RW0 == RW1, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-017 When ZERO_REG=1:
- writes to address 0 SHALL be ignored;
- busX/busY SHALL read 0 for address 0;
- busyX/busyY SHALL be 0 for address 0;
- a reserve of address 0 SHALL be ignored.
REQ-018 The scoreboard SHALL hold one busy bit per register.
- On a rising edge with RSV=1, busy[RR] SHALL be set to 1.
- On a rising edge, an enabled write on either port SHALL clear busy[RWn].
REQ-019 When a reserve and a write target the same address on the same edge, the reserve SHALL win and busy SHALL remain 1, because the write retires an older producer.
REQ-020 busyX SHALL equal busy[RX] and busyY SHALL equal busy[RY], both combinational.
REQ-021 A write to a register that is not busy SHALL be legal; it SHALL update data and leave busy at 0.
REQ-022 Reserving a register that is already busy SHALL be legal and SHALL leave busy at 1.
REQ-023 Read-during-write behaviour SHALL be set by REQ-027 and REQ-028.

Reset
REQ-024 Asserting Reset SHALL immediately, without waiting for Clk, clear all registers to 0 and all busy bits to 0.
REQ-025 While Reset=1, busX, busY, busyX and busyY SHALL all be 0.
- Writes and reserves SHALL be ignored.
- The first update SHALL occur on the first rising Clk edge after Reset deasserts.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight write or reserve in that cycle.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, same-cycle write-to-read forwarding SHALL apply:
- if RX (or RY) matches an enabled write address this cycle, busX (busY) SHALL show that write's busWn, with port 1 taking priority;
- the corresponding busyX/busyY SHALL read 0 unless RSV=1 with RR equal to that address;
- ZERO_REG rules SHALL still apply;
- forwarding SHALL be suppressed while Reset=1.
REQ-028 With REGFILE_BYPASS_EN undefined, reads SHALL return only stored state; a written value SHALL become visible in the cycle after the committing edge.

Verification
REQ-029 Reset test: write 0xDEADBEEF to r5, then assert Reset asynchronously between edges -> busX (RX=5) = 0 immediately; after release, busX = 0.
REQ-030 Dual write, same address: WEN0=WEN1=1, RW0=RW1=7, busW0=0x11, busW1=0x22 -> after the edge, reg7 = 0x22.
REQ-031 Zero register with ZERO_REG=1: write 0xFFFFFFFF to r0 and RSV with RR=0 -> busX = 0 and busyX = 0 for RX=0; with ZERO_REG=0 the same stimulus -> busX = 0xFFFFFFFF and busyX = 1.
REQ-032 Scoreboard: RSV on r3 -> busyX = 1; two cycles later WEN0 to r3 with 0x55 -> busyX = 0 and busX = 0x55; reserve and write r3 on the same edge -> busyX stays 1.
REQ-033 Bypass, write r9 = 0x1234 with RX=9 in the same cycle: with REGFILE_BYPASS_EN, busX = 0x1234 before the edge; without it, busX shows the old value and 0x1234 appears after the edge.
